// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback types, source indices and the wrap-aware age compare
package wb_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int SEQ_W  = 6;
    localparam int SRC_LOAD_U = 0;
    localparam int SRC_EXEC_U = 1;
    localparam int SRC_EXEC_V = 2;
    localparam int SRC_MUL_U  = 3;
    localparam int SRC_FPU_L1 = 4;
    localparam int SRC_FPU_L2 = 5;
    localparam int SRC_FPU_L3 = 6;
    localparam int SRC_FPU_L4 = 7;
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } wb_entry_t;
    // a is older than b when a-b is negative in SEQ_W-bit wrap arithmetic
    function automatic logic seq_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] d;
        d = a - b;
        return d[SEQ_W-1];
    endfunction
endpackage

// File: rtl/wb_src_queue.sv
// wb_src_queue: per-source circular FIFO of writeback entries
module wb_src_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  wb_entry_t               din_i,
    output wb_entry_t               head_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_d_o
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t      mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [AW:0]    count_q;
    logic           do_rd, do_wr;
    assign empty_o   = count_q == '0;
    assign full_o    = count_q == (AW+1)'(DEPTH);
    assign do_rd     = pop_i && !empty_o;
    // a pop frees the slot in the same cycle, so a full queue still accepts a push
    assign do_wr     = push_i && (!full_o || do_rd);
    assign count_d_o = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    assign head_o    = mem_q[rd_ptr_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d_o;
        end
    end
endmodule

// File: rtl/wb_merge_arbiter.sv
// wb_merge_arbiter: oldest-first merge of N_SRC queued result channels onto N_WP GPR write ports
module wb_merge_arbiter
    import wb_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter int N_WP    = 2,
    parameter int DEPTH   = 4,
    parameter int ZERO_HW = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     interlock_i,
    input  logic [N_SRC-1:0]         src_valid_i,
    input  logic [N_SRC*REG_W-1:0]   src_rd_i,
    input  logic [N_SRC*DATA_W-1:0]  src_data_i,
    input  logic [N_SRC*SEQ_W-1:0]   src_seq_i,
    output logic [N_WP-1:0]          wp_we_o,
    output logic [N_WP*REG_W-1:0]    wp_addr_o,
    output logic [N_WP*DATA_W-1:0]   wp_data_o,
    output logic                     stall_req_o,
    output logic                     overflow_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = N_SRC > 1 ? $clog2(N_SRC) : 1;
    wb_entry_t              head [N_SRC];
    wb_entry_t              cand [N_SRC];
    logic [CW-1:0]          cnt_d [N_SRC];
    logic [IW-1:0]          sel [N_WP];
    logic [N_SRC-1:0]       empty, full, cand_v, grant, push, pop;
    logic [N_WP-1:0]        sel_v, we_d, we_q;
    logic [N_WP*REG_W-1:0]  addr_q;
    logic [N_WP*DATA_W-1:0] data_q;
    logic                   stall_d, stall_q, ovf_d, ovf_q;
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        wb_entry_t inc;
        assign inc       = '{rd: src_rd_i[i*REG_W +: REG_W], data: src_data_i[i*DATA_W +: DATA_W],
                             seq: src_seq_i[i*SEQ_W +: SEQ_W]};
        assign cand_v[i] = !interlock_i && (!empty[i] || src_valid_i[i]);
        assign cand[i]   = empty[i] ? inc : head[i];
        assign pop[i]    = grant[i] && !empty[i];
        assign push[i]   = !interlock_i && src_valid_i[i] && (!empty[i] || !grant[i]);
        wb_src_queue #(.DEPTH(DEPTH)) u_q (
            .clk       (clk),
            .rst       (rst),
            .push_i    (push[i]),
            .pop_i     (pop[i]),
            .din_i     (inc),
            .head_o    (head[i]),
            .empty_o   (empty[i]),
            .full_o    (full[i]),
            .count_d_o (cnt_d[i])
        );
    end
    always_comb begin : p_sel
        logic [N_SRC-1:0] avail;
        logic [IW-1:0]    b;
        logic             found;
        avail = cand_v;
        grant = '0;
        sel_v = '0;
        for (int r = 0; r < N_WP; r++) begin
            sel[r] = '0;
            b      = '0;
            found  = 1'b0;
            for (int i = 0; i < N_SRC; i++)
                if (avail[i] && (!found || seq_older(cand[i].seq, cand[b].seq))) begin
                    b     = IW'(i);
                    found = 1'b1;
                end
            if (found) begin
                sel[r]   = b;
                sel_v[r] = 1'b1;
                avail[b] = 1'b0;
                grant[b] = 1'b1;
            end
        end
    end
    // among granted entries to one register only the youngest keeps its write enable
    always_comb begin
        we_d = '0;
        for (int r = 0; r < N_WP; r++) begin
            we_d[r] = sel_v[r] && !(ZERO_HW != 0 && cand[sel[r]].rd == '0);
            for (int q = 0; q < N_WP; q++)
                if (q != r && sel_v[q] && cand[sel[q]].rd == cand[sel[r]].rd &&
                    seq_older(cand[sel[r]].seq, cand[sel[q]].seq))
                    we_d[r] = 1'b0;
        end
    end
    always_comb begin
        stall_d = 1'b0;
        for (int i = 0; i < N_SRC; i++) stall_d |= cnt_d[i] >= CW'(DEPTH - 1);
    end
    assign ovf_d = ovf_q | |(push & full & ~pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
            for (int r = 0; r < N_WP; r++)
                if (we_d[r]) begin
                    addr_q[r*REG_W +: REG_W]   <= cand[sel[r]].rd;
                    data_q[r*DATA_W +: DATA_W] <= cand[sel[r]].data;
                end
        end
    end
    assign wp_we_o     = we_q;
    assign wp_addr_o   = addr_q;
    assign wp_data_o   = data_q;
    assign stall_req_o = stall_q;
    assign overflow_o  = ovf_q;
endmodule
